// File: rtl/decoder_pkg.sv
// Shared types and defaults for the strobed 3-to-8 decoder.
// onehot_check is used by the RTL assertion and the bench.
package decoder_pkg;

  localparam int DEF_IN_W  = 3;
  localparam int DEF_HOLD  = 4;
  localparam int DEF_GAP   = 1;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

  function automatic logic onehot_check(
    input logic [31:0] v
  );
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/decoder_3_to_8_strobe_if.sv
// Index handshake plus decoded outputs.
// master drives the index; slave is the decoder.
interface decoder_3_to_8_strobe_if #(
  parameter int IN_W = 3
);

  logic                 in_valid;
  logic [IN_W-1:0]      in;
  logic                 in_ready;
  logic [2**IN_W-1:0]   y;
  logic                 active;
  logic [IN_W-1:0]      code;

  modport master (
    output in_valid,
    output in,
    input  in_ready,
    input  y,
    input  active,
    input  code
  );

  modport slave (
    input  in_valid,
    input  in,
    output in_ready,
    output y,
    output active,
    output code
  );

endinterface

// File: rtl/binary_decoder.sv
// Combinational binary to one-hot decoder with enable.
// Output is all-zero while en is low.
module binary_decoder #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]    code,
  input  logic               en,
  output logic [2**IN_W-1:0] y
);

  localparam int OUT_W = 2**IN_W;

  assign y = en ? (OUT_W'(1) << code) : '0;

endmodule

// File: rtl/decoder_3_to_8_strobe.sv
// Strobed 3-to-8 decoder: holds each code HOLD cycles,
// then blanks for GAP cycles; optional auto-scan.
module decoder_3_to_8_strobe #(
  parameter int IN_W  = decoder_pkg::DEF_IN_W,
  parameter int HOLD  = decoder_pkg::DEF_HOLD,
  parameter int GAP   = decoder_pkg::DEF_GAP,
  parameter int CNT_W = decoder_pkg::DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic scan,
  decoder_3_to_8_strobe_if.slave bus
);

  import decoder_pkg::state_t;
  import decoder_pkg::IDLE;
  import decoder_pkg::ACTIVE;
  import decoder_pkg::onehot_check;

  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit HAS_GAP = (GAP > 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   code_q, code_d;
  logic [IN_W-1:0]   sidx_q, sidx_d;
  logic              fscan_q, fscan_d;

  logic              start;
  logic              finish;
  logic [IN_W-1:0]   start_code;
  logic [IN_W-1:0]   nxt_idx;
  logic              act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      sidx_q  <= '0;
      fscan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      sidx_q  <= sidx_d;
      fscan_q <= fscan_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    sidx_d     = sidx_q;
    fscan_d    = fscan_q;
    start      = 1'b0;
    finish     = 1'b0;
    start_code = code_q;
    nxt_idx    = sidx_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (scan) begin
            start      = 1'b1;
            start_code = sidx_q;
            fscan_d    = 1'b1;
          end else if (bus.in_valid) begin
            start      = 1'b1;
            start_code = bus.in;
            fscan_d    = 1'b0;
          end
        end
        ACTIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (HAS_GAP) begin
            state_d = decoder_pkg::GAP;
            cnt_d   = GAP_LD;
          end else begin
            finish = 1'b1;
          end
        end
        decoder_pkg::GAP: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             finish = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      // A scan code advances the index when it retires,
      // so a later scan resumes from the next line.
      if (finish) begin
        nxt_idx = fscan_q ? sidx_q + 1'b1 : sidx_q;
        sidx_d  = nxt_idx;
        if (scan) begin
          start      = 1'b1;
          start_code = nxt_idx;
          fscan_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      if (start) begin
        state_d = ACTIVE;
        cnt_d   = HOLD_LD;
        code_d  = start_code;
      end
    end
  end

  always_comb begin
    bus.in_ready = (state_q == IDLE) & en & ~scan;
    act          = (state_q == ACTIVE) & en;
    bus.active   = act;
    bus.code     = code_q;
  end

  binary_decoder #(
    .IN_W (IN_W)
  ) u_dec (
    .code (code_q),
    .en   (act),
    .y    (bus.y)
  );

  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    onehot_check(32'(bus.y))
  );

endmodule

// File: tb/tb_decoder_3_to_8_strobe.sv
// Random and directed stimulus against a countdown model
// for two decoders: HOLD=4/GAP=1 and HOLD=3/GAP=0.
module tb_decoder_3_to_8_strobe;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       scan;
  logic       in_valid;
  logic [2:0] in_v;

  int total = 0;
  int bad   = 0;

  int hold_p[2];
  int gap_p[2];
  int left[2];
  int mcode[2];
  int sidx[2];
  bit fscan[2];

  logic [7:0] y_w[2];
  logic       act_w[2];
  logic       rdy_w[2];
  logic [2:0] code_w[2];

  always #5 clk = ~clk;

  decoder_3_to_8_strobe_if #(.IN_W(3)) bus0 ();
  decoder_3_to_8_strobe_if #(.IN_W(3)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in       = in_v;
  assign bus1.in_valid = in_valid;
  assign bus1.in       = in_v;

  assign y_w[0]    = bus0.y;
  assign act_w[0]  = bus0.active;
  assign rdy_w[0]  = bus0.in_ready;
  assign code_w[0] = bus0.code;
  assign y_w[1]    = bus1.y;
  assign act_w[1]  = bus1.active;
  assign rdy_w[1]  = bus1.in_ready;
  assign code_w[1] = bus1.code;

  decoder_3_to_8_strobe #(
    .IN_W(3), .HOLD(4), .GAP(1), .CNT_W(8)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .scan  (scan),
    .bus   (bus0.slave)
  );

  decoder_3_to_8_strobe #(
    .IN_W(3), .HOLD(3), .GAP(0), .CNT_W(8)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .scan  (scan),
    .bus   (bus1.slave)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k]  = 0;
      mcode[k] = 0;
      sidx[k]  = 0;
      fscan[k] = 1'b0;
    end
  endtask

  task automatic model_start(input int k, input int c,
                             input bit f);
    mcode[k] = c;
    left[k]  = hold_p[k] + gap_p[k];
    fscan[k] = f;
  endtask

  // left counts every remaining output cycle of a code,
  // HOLD lit cycles followed by GAP blank cycles.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (en) begin
        if (left[k] == 0) begin
          if (scan)          model_start(k, sidx[k], 1'b1);
          else if (in_valid) model_start(k, int'(in_v), 1'b0);
        end else begin
          left[k]--;
          if (left[k] == 0) begin
            if (fscan[k]) sidx[k] = (sidx[k] + 1) % 8;
            if (scan) model_start(k, sidx[k], 1'b1);
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit lit;
    int ey;
    for (int k = 0; k < 2; k++) begin
      lit = en && (left[k] > gap_p[k]);
      ey  = lit ? (1 << mcode[k]) : 0;
      check($sformatf("y%0d", k), 32'(y_w[k]), 32'(ey));
      check($sformatf("active%0d", k),
            32'(act_w[k]), 32'(lit));
      check($sformatf("in_ready%0d", k), 32'(rdy_w[k]),
            32'(en && !scan && left[k] == 0));
      check($sformatf("code%0d", k),
            32'(code_w[k]), 32'(mcode[k]));
      check($sformatf("onehot%0d", k),
            32'(onehot_check(32'(y_w[k]))), 32'd1);
    end
  endtask

  task automatic cycle(input bit v, input int i,
                       input bit s, input bit e);
    @(negedge clk);
    in_valid = v;
    in_v     = 3'(i);
    scan     = s;
    en       = e;
    #1 check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  bit rs;

  initial begin
    hold_p[0] = 4; gap_p[0] = 1;
    hold_p[1] = 3; gap_p[1] = 0;
    rst_n = 1'b0; en = 1'b1; scan = 1'b0;
    in_valid = 1'b0; in_v = '0;
    model_reset();
    #2 check_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    cycle(1, 5, 0, 1);
    for (int n = 0; n < 7; n++) cycle(0, 0, 0, 1);

    cycle(1, 3, 0, 1);
    for (int n = 0; n < 12; n++) cycle(1, 6, 0, 1);
    for (int n = 0; n < 6; n++) cycle(0, 0, 0, 1);

    for (int n = 0; n < 45; n++) cycle(0, 0, 1, 1);
    for (int n = 0; n < 8; n++)  cycle(0, 0, 0, 1);
    for (int n = 0; n < 12; n++) cycle(0, 0, 1, 1);
    for (int n = 0; n < 8; n++)  cycle(0, 0, 0, 1);

    cycle(1, 2, 0, 1);
    cycle(0, 0, 0, 1);
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0);
    for (int n = 0; n < 6; n++) cycle(0, 0, 0, 1);

    cycle(1, 7, 0, 1);
    cycle(0, 0, 0, 1);
    async_reset();
    for (int n = 0; n < 20; n++) cycle(0, 0, 1, 1);

    rs = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0) rs = ~rs;
      if (n == 300) async_reset();
      cycle($urandom_range(1), $urandom_range(7), rs,
            $urandom_range(7) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
